// File: rtl/lu_sweep_unit.sv
// lu_sweep_unit
//   Operand sequencer for the logic-unit/multiplexer datapath. Accepts one
//   (a, b) pair, then emits four beats applying xnor, xor, nor and or in turn,
//   each on a valid/ready handshake toward the downstream consumer.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   in_valid   : upstream operand pair present on a/b
//   in_ready   : block can accept an operand pair (IDLE)
//   a, b       : WIDTH-bit operands, captured on the input handshake
//   out_valid  : result/op/last are valid (RUN)
//   out_ready  : downstream accepts the current beat
//   op         : function code of current beat (0 xnor, 1 xor, 2 nor, 3 or)
//   result     : bitwise function of the captured operands, 0 when idle
//   last       : high on the op=3 beat only
module lu_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    function automatic logic [WIDTH-1:0] lu_func(
        input logic [1:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (f)
            2'd0:    r = ~(x ^ y);
            2'd1:    r = x ^ y;
            2'd2:    r = ~(x | y);
            default: r = x | y;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= 2'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Advance only on an accepted beat; otherwise hold for backpressure.
                    if (out_ready) begin
                        if (op_q == 2'd3) begin
                            op_q    <= 2'd0;
                            state_q <= IDLE;
                        end else begin
                            op_q <= op_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only, so no input reaches an output
    // combinationally and in_ready/out_valid are mutually exclusive by construction.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign op        = op_q;
    assign result    = out_valid ? lu_func(op_q, a_q, b_q) : '0;
    assign last      = out_valid && (op_q == 2'd3);

endmodule

// File: tb/tb_lu_sweep_unit.sv
module tb_lu_sweep_unit;

    logic clock;
    logic reset;

    // WIDTH=4 instance
    logic       in_valid4, in_ready4, out_valid4, out_ready4, last4;
    logic [3:0] a4, b4, result4;
    logic [1:0] op4;

    // WIDTH=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, last1;
    logic [0:0] a1, b1, result1;
    logic [1:0] op1;

    int checks;
    int failures;

    lu_sweep_unit #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .op(op4), .result(result4), .last(last4)
    );

    lu_sweep_unit #(.WIDTH(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .op(op1), .result(result1), .last(last1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]       a;
        logic [3:0]       b;
        logic [3:0][3:0]  r;   // r[j] = expected result for op=j
    } vec4_t;

    typedef struct {
        logic       a;
        logic       b;
        logic [3:0] r;         // r[j] = expected result bit for op=j
    } vec1_t;

    vec4_t tab4[5];
    vec1_t tab1[4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sweep4(input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0][3:0] rv, input string tag);
        chk({tag, " pre in_ready"}, 32'(in_ready4), 1);
        chk({tag, " pre out_valid"}, 32'(out_valid4), 0);
        a4 = av; b4 = bv; in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0; a4 = ~av; b4 = ~bv;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s op%0d out_valid", tag, j), 32'(out_valid4), 1);
            chk($sformatf("%s op%0d in_ready", tag, j), 32'(in_ready4), 0);
            chk($sformatf("%s op%0d op", tag, j), 32'(op4), 32'(j));
            chk($sformatf("%s op%0d result", tag, j), 32'(result4), 32'(rv[j]));
            chk($sformatf("%s op%0d last", tag, j), 32'(last4), (j == 3) ? 1 : 0);
            step();
        end
        chk({tag, " post out_valid"}, 32'(out_valid4), 0);
        chk({tag, " post in_ready"}, 32'(in_ready4), 1);
        chk({tag, " post result"}, 32'(result4), 0);
        chk({tag, " post last"}, 32'(last4), 0);
    endtask

    task automatic sweep1(input logic av, input logic bv, input logic [3:0] rv, input string tag);
        int lastcnt;
        lastcnt = 0;
        chk({tag, " pre in_ready"}, 32'(in_ready1), 1);
        a1 = av; b1 = bv; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0; a1 = ~av; b1 = ~bv;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s op%0d op", tag, j), 32'(op1), 32'(j));
            chk($sformatf("%s op%0d result", tag, j), 32'(result1), 32'(rv[j]));
            if (last1) lastcnt++;
            step();
        end
        chk({tag, " last count"}, 32'(lastcnt), 1);
        chk({tag, " post in_ready"}, 32'(in_ready1), 1);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        in_valid4 = 1'b0; a4 = 4'hA; b4 = 4'h5; out_ready4 = 1'b0;
        in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; out_ready1 = 1'b0;

        // Vectors: {a, b, {or, nor, xor, xnor}}
        tab4[0] = '{a: 4'b0011, b: 4'b0101, r: {4'b0111, 4'b1000, 4'b0110, 4'b1001}};
        tab4[1] = '{a: 4'b1111, b: 4'b0000, r: {4'b1111, 4'b0000, 4'b1111, 4'b0000}};
        tab4[2] = '{a: 4'b0000, b: 4'b0000, r: {4'b0000, 4'b1111, 4'b0000, 4'b1111}};
        tab4[3] = '{a: 4'b1010, b: 4'b1100, r: {4'b1110, 4'b0001, 4'b0110, 4'b1001}};
        tab4[4] = '{a: 4'b1111, b: 4'b1111, r: {4'b1111, 4'b0000, 4'b0000, 4'b1111}};
        // r bits ordered {or, nor, xor, xnor}
        tab1[0] = '{a: 1'b0, b: 1'b0, r: 4'b0101};
        tab1[1] = '{a: 1'b0, b: 1'b1, r: 4'b1010};
        tab1[2] = '{a: 1'b1, b: 1'b0, r: 4'b1010};
        tab1[3] = '{a: 1'b1, b: 1'b1, r: 4'b1001};

        // Reset state
        step();
        reset = 1'b0;
        chk("reset in_ready", 32'(in_ready4), 1);
        chk("reset out_valid", 32'(out_valid4), 0);
        chk("reset op", 32'(op4), 0);
        chk("reset result", 32'(result4), 0);
        chk("reset last", 32'(last4), 0);
        chk("reset w1 in_ready", 32'(in_ready1), 1);

        // Table-driven full sweeps
        for (int i = 0; i < 5; i++)
            sweep4(tab4[i].a, tab4[i].b, tab4[i].r, $sformatf("vec%0d", i));

        // Backpressure during op=1
        a4 = 4'b0011; b4 = 4'b0101; in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("bp op0 result", 32'(result4), 32'b1001);
        step();
        out_ready4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp hold%0d op", k), 32'(op4), 1);
            chk($sformatf("bp hold%0d result", k), 32'(result4), 32'b0110);
            chk($sformatf("bp hold%0d last", k), 32'(last4), 0);
            step();
        end
        out_ready4 = 1'b1;
        chk("bp release op", 32'(op4), 1);
        step();
        chk("bp resume op", 32'(op4), 2);
        chk("bp resume result", 32'(result4), 32'b1000);
        step();
        chk("bp op3 result", 32'(result4), 32'b0111);
        chk("bp op3 last", 32'(last4), 1);
        step();
        chk("bp idle", 32'(in_ready4), 1);

        // Input ignored while running
        a4 = 4'b1111; b4 = 4'b0000; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("ign op0 result", 32'(result4), 32'b0000);
        step();
        in_valid4 = 1'b1; a4 = 4'b0000;
        chk("ign in_ready", 32'(in_ready4), 0);
        chk("ign op1 result", 32'(result4), 32'b1111);
        step();
        chk("ign op2 result", 32'(result4), 32'b0000);
        step();
        chk("ign op3 result", 32'(result4), 32'b1111);
        chk("ign op3 last", 32'(last4), 1);
        step();
        in_valid4 = 1'b0;
        chk("ign idle out_valid", 32'(out_valid4), 0);
        chk("ign idle in_ready", 32'(in_ready4), 1);

        // Reset mid-sweep during op=2
        a4 = 4'b0011; b4 = 4'b0101; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        chk("rst mid op", 32'(op4), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst mid out_valid", 32'(out_valid4), 0);
        chk("rst mid op0", 32'(op4), 0);
        chk("rst mid result", 32'(result4), 0);
        chk("rst mid last", 32'(last4), 0);
        chk("rst mid in_ready", 32'(in_ready4), 1);
        step();
        chk("rst no partial beat", 32'(out_valid4), 0);
        sweep4(4'b1010, 4'b1100, tab4[3].r, "post_rst");

        // Back-to-back pairs with in_valid held high
        a4 = 4'b0011; b4 = 4'b0101; in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();                                   // accepted at edge k
        a4 = 4'b1010; b4 = 4'b1100;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("b2b first op%0d result", j), 32'(result4), 32'(tab4[0].r[j]));
            chk($sformatf("b2b first op%0d in_ready", j), 32'(in_ready4), 0);
            step();
        end
        chk("b2b gap in_ready", 32'(in_ready4), 1);   // cycle k+5
        chk("b2b gap out_valid", 32'(out_valid4), 0);
        step();                                   // accepted at edge k+5
        in_valid4 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("b2b second op%0d op", j), 32'(op4), 32'(j));
            chk($sformatf("b2b second op%0d result", j), 32'(result4), 32'(tab4[3].r[j]));
            step();
        end
        chk("b2b end in_ready", 32'(in_ready4), 1);

        // WIDTH=1 truth tables
        for (int i = 0; i < 4; i++)
            sweep1(tab1[i].a, tab1[i].b, tab1[i].r, $sformatf("w1_ab%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
